plab4_net_router_input_queue: RTL and testbench
===============================================

Name: plab4_net_router_input_queue

Overview:
- Per-input-port message buffer in the adaptive ring router. It sits directly upstream of the router's input terminal/channel control.
- Accepts messages from the terminal or the ring channel with a val/rdy handshake and stores them in a circular FIFO.
- Presents the head message and its extracted destination field to the input control as dest/in_val, and consumes its in_rdy as out_rdy.
- Exports the number of free entries. Neighbouring input controls use this count (num_free0/num_free2) for bubble flow control.

Parameters:
- p_msg_nbits, 44, width of one network message.
- p_num_entries, 4, FIFO depth; must be a power of two and at least 2.
- p_num_routers, 8, number of routers on the ring; sets the destination field width.
- p_dest_lsb, 36, bit position of the LSB of the destination field within the message.
- c_dest_nbits, $clog2(p_num_routers), derived; not set from outside.
- c_addr_nbits, $clog2(p_num_entries), derived; read and write pointer width.
- c_free_nbits, $clog2(p_num_entries+1), derived; width of num_free.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_val  in  1  enqueue message valid.
- in_rdy  out  1  queue can accept a message this cycle.
- in_msg  in  p_msg_nbits  enqueue message.
- out_val  out  1  head message valid; drives the input control's in_val.
- out_rdy  in  1  downstream accepts the head; driven by the input control's in_rdy.
- out_msg  out  p_msg_nbits  head message.
- out_dest  out  c_dest_nbits  out_msg[p_dest_lsb +: c_dest_nbits]; drives the input control's dest.
- num_free  out  c_free_nbits  number of empty entries.

Behaviour:
- State: entry array, write pointer wr_ptr, read pointer rd_ptr, occupancy count (0..p_num_entries).
- Reset (reset=0, asynchronous): wr_ptr=0, rd_ptr=0, count=0.
  - Outputs during and after reset: in_rdy=1, out_val=0, num_free=p_num_entries.
  - Entry contents are not reset.
  - A reset asserted mid-operation discards all stored messages immediately, without waiting for a clock edge.
- Handshake signals:
  - in_rdy = (count != p_num_entries), purely from registered state; it does not depend on out_rdy.
  - enq = in_val & in_rdy.
  - out_val = (count != 0).
  - deq = out_val & out_rdy.
- Enqueue: the entry at wr_ptr is written with in_msg, then wr_ptr = wr_ptr+1. The pointer wraps modulo p_num_entries (natural c_addr_nbits overflow).
- Dequeue: rd_ptr = rd_ptr+1, with the same wrap rule.
- Head outputs: out_msg = entry at rd_ptr, combinational read. It is don't-care when out_val=0; a bench must not check it then.
- Latency: a message enqueued at edge N is visible on out_val/out_msg in the cycle after edge N. There is no same-cycle bypass when empty.
- Count update:
  - enq only: count+1.
  - deq only: count-1.
  - enq and deq together: count unchanged, and both pointers advance.
  - neither: count unchanged.
- num_free = p_num_entries - count, registered-state derived, width c_free_nbits.
- Empty (count=0): out_val=0, so out_rdy is ignored; an enq in the same cycle is legal.
- Full (count=p_num_entries): in_rdy=0, so in_val is ignored and the incoming message is not written.
  - An enq cannot be paired with a deq while full. Throughput returns the cycle after a deq.
- Ordering: strict FIFO; no reordering and no message loss.
- No enqueue is ever lost in any state except assertion of reset.
- Assertions (bench):
  - count never exceeds p_num_entries and never underflows.
  - wr_ptr - rd_ptr (mod p_num_entries) equals count, except when full, where the pointers are equal.

Test Plan:
- Reset then idle: hold reset=0 for 2 cycles, release -> in_rdy=1, out_val=0, num_free=4 for all following idle cycles.
- Single message: enq in_msg with dest field=5, out_rdy=0 -> next cycle out_val=1, out_dest=5, num_free=3; raise out_rdy -> following cycle out_val=0, num_free=4.
- Fill to full: 4 back-to-back enqs with messages A,B,C,D, out_rdy=0 -> num_free 3,2,1,0 and in_rdy=0 after the 4th. A 5th in_val is held with E for 3 cycles -> nothing written. Then drain -> A,B,C,D in order, then out_val=0.
- Simultaneous enq/deq: with 2 entries queued, assert in_val and out_rdy together for 6 cycles -> num_free stays 2 and the output order equals the input order. Pointers wrap past index 3 with no corruption.
- Empty-boundary streaming: empty queue, out_rdy=1 always, enq one message per cycle -> each message appears exactly one cycle after its enq, out_val=1 continuously from the second cycle, num_free toggles between 4 and 3 only.
- Reset mid-operation: with 3 entries queued, drop reset asynchronously between edges -> out_val=0 and num_free=4 immediately. After release, enq F -> F is the next output (old entries gone).

Source files
------------

// File: rtl/plab4_net_router_input_queue.sv
// Per-input-port circular FIFO for the ring router. It exposes the head message
// with its destination field, and the free-entry count used for bubble flow control.
module plab4_net_router_input_queue #(
   parameter  int p_msg_nbits   = 44,
   parameter  int p_num_entries = 4,
   parameter  int p_num_routers = 8,
   parameter  int p_dest_lsb    = 36,
   localparam int c_dest_nbits  = $clog2(p_num_routers),
   localparam int c_addr_nbits  = $clog2(p_num_entries),
   localparam int c_free_nbits  = $clog2(p_num_entries+1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_val,
   output logic                    in_rdy,
   input  logic [p_msg_nbits-1:0]  in_msg,
   output logic                    out_val,
   input  logic                    out_rdy,
   output logic [p_msg_nbits-1:0]  out_msg,
   output logic [c_dest_nbits-1:0] out_dest,
   output logic [c_free_nbits-1:0] num_free
);

   localparam logic [c_free_nbits-1:0] c_depth = c_free_nbits'(p_num_entries);

   logic [p_msg_nbits-1:0]  entries [p_num_entries];
   logic [c_addr_nbits-1:0] wr_ptr;
   logic [c_addr_nbits-1:0] rd_ptr;
   logic [c_free_nbits-1:0] count;
   logic                    enq;
   logic                    deq;

   // Handshakes depend only on registered state, so in_rdy never waits on out_rdy.
   assign in_rdy   = (count != c_depth);
   assign out_val  = (count != '0);
   assign enq      = in_val & in_rdy;
   assign deq      = out_val & out_rdy;
   assign num_free = c_depth - count;
   assign out_msg  = entries[rd_ptr];
   assign out_dest = out_msg[p_dest_lsb +: c_dest_nbits];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (enq) wr_ptr <= wr_ptr + c_addr_nbits'(1);
         if (deq) rd_ptr <= rd_ptr + c_addr_nbits'(1);
         if (enq && !deq)      count <= count + c_free_nbits'(1);
         else if (deq && !enq) count <= count - c_free_nbits'(1);
      end
   end

   // Storage is deliberately not reset; out_val gates any stale contents.
   always_ff @(posedge clk) begin
      if (enq) entries[wr_ptr] <= in_msg;
   end

endmodule

// File: tb/tb_plab4_net_router_input_queue.sv
// Randomized bench for the router input queue: a queue-based reference model
// is compared against the DUT on every falling edge, plus directed literal checks.
module tb_plab4_net_router_input_queue;

   localparam int N  = 4;
   localparam int MW = 44;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_val;
   logic          in_rdy;
   logic [MW-1:0] in_msg;
   logic          out_val;
   logic          out_rdy;
   logic [MW-1:0] out_msg;
   logic [2:0]    out_dest;
   logic [2:0]    num_free;

   int checks = 0;
   int errors = 0;

   logic [MW-1:0] model_q [$];

   plab4_net_router_input_queue dut (
      .clk      (clk),
      .reset    (reset),
      .in_val   (in_val),
      .in_rdy   (in_rdy),
      .in_msg   (in_msg),
      .out_val  (out_val),
      .out_rdy  (out_rdy),
      .out_msg  (out_msg),
      .out_dest (out_dest),
      .num_free (num_free)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [MW-1:0] rand_msg();
      return MW'({$urandom(), $urandom()});
   endfunction

   // Reference model: a plain FIFO of at most N messages, cleared by reset at once.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         model_q.delete();
      end else begin
         automatic bit m_enq = in_val && (model_q.size() < N);
         automatic bit m_deq = out_rdy && (model_q.size() > 0);
         if (m_deq) void'(model_q.pop_front());
         if (m_enq) model_q.push_back(in_msg);
      end
   end

   always @(negedge clk) begin
      automatic logic [1:0] diff = dut.wr_ptr - dut.rd_ptr;
      chk("in_rdy",   in_rdy,   model_q.size() != N);
      chk("out_val",  out_val,  model_q.size() != 0);
      chk("num_free", num_free, N - model_q.size());
      if (model_q.size() != 0) begin
         chk("out_msg",  out_msg,  model_q[0]);
         chk("out_dest", out_dest, model_q[0][38:36]);
      end
      chk("count_le_depth", dut.count <= 3'(N), 1'b1);
      chk("ptr_vs_count", diff, dut.count[1:0]);
   end

   initial begin
      logic [MW-1:0] abcd [4];
      logic [MW-1:0] m;
      logic [MW-1:0] f;

      reset = 1'b0; in_val = 1'b0; out_rdy = 1'b0; in_msg = '0;
      step(); step();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_in_rdy", in_rdy, 1'b1);
         chk("idle_out_val", out_val, 1'b0);
         chk("idle_num_free", num_free, 3'd4);
      end

      // single message with destination 5
      m = rand_msg(); m[38:36] = 3'd5;
      in_msg = m; in_val = 1'b1;
      step();
      in_val = 1'b0;
      chk("single_val", out_val, 1'b1);
      chk("single_dest", out_dest, 3'd5);
      chk("single_free", num_free, 3'd3);
      out_rdy = 1'b1;
      step();
      out_rdy = 1'b0;
      chk("single_gone", out_val, 1'b0);
      chk("single_free4", num_free, 3'd4);

      // fill to full, hold a blocked message, then drain
      for (int i = 0; i < 4; i++) begin
         abcd[i] = rand_msg();
         in_msg = abcd[i]; in_val = 1'b1;
         step();
         chk("fill_free", num_free, 3'(3 - i));
      end
      chk("full_in_rdy", in_rdy, 1'b0);
      in_msg = rand_msg();
      step(); step(); step();
      chk("full_hold_free", num_free, 3'd0);
      in_val = 1'b0;
      out_rdy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("drain_order", out_msg, abcd[i]);
         step();
      end
      chk("drain_empty", out_val, 1'b0);
      out_rdy = 1'b0;

      // simultaneous enq/deq with two queued, pointers wrap
      for (int i = 0; i < 2; i++) begin
         in_msg = rand_msg(); in_val = 1'b1;
         step();
      end
      out_rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_msg = rand_msg();
         step();
         chk("simul_free", num_free, 3'd2);
      end
      in_val = 1'b0;
      step(); step(); step();
      chk("simul_drained", out_val, 1'b0);

      // empty-boundary streaming
      for (int i = 0; i < 8; i++) begin
         m = rand_msg();
         in_msg = m; in_val = 1'b1;
         step();
         chk("stream_val", out_val, 1'b1);
         chk("stream_msg", out_msg, m);
         chk("stream_free", num_free, 3'd3);
      end
      in_val = 1'b0;
      step();
      chk("stream_end", num_free, 3'd4);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         in_val  = ($urandom_range(0, 99) < 60);
         out_rdy = ($urandom_range(0, 99) < 50);
         in_msg  = rand_msg();
         step();
      end

      // asynchronous reset with three queued
      in_val = 1'b0; out_rdy = 1'b1;
      repeat (6) step();
      out_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_msg = rand_msg(); in_val = 1'b1;
         step();
      end
      in_val = 1'b0;
      chk("pre_reset_free", num_free, 3'd1);
      #2 reset = 1'b0;
      #1;
      chk("async_out_val", out_val, 1'b0);
      chk("async_free", num_free, 3'd4);
      step();
      reset = 1'b1;
      f = rand_msg();
      in_msg = f; in_val = 1'b1;
      step();
      in_val = 1'b0;
      chk("post_reset_val", out_val, 1'b1);
      chk("post_reset_msg", out_msg, f);
      out_rdy = 1'b1;
      step();
      chk("post_reset_empty", out_val, 1'b0);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
